// File: rtl/dsp_wb_regfile_slave_pkg.sv
// rtl/dsp_wb_regfile_slave_pkg.sv - shared constants and types for the divisor register file
package dsp_wb_regfile_slave_pkg;

    localparam int          REG_COUNT          = 16;
    localparam logic [15:0] BASE_ADR_DEFAULT   = 16'h4000;
    localparam logic [3:0]  DIV_LO_IDX_DEFAULT = 4'hA;
    localparam logic [3:0]  DIV_HI_IDX_DEFAULT = 4'hB;

    typedef enum logic [0:0] {
        IDLE            = 1'b0,
        WAIT_WRITE_DONE = 1'b1
    } upd_state_e;

    function automatic logic is_divisor_idx(input logic [3:0] idx,
                                            input logic [3:0] lo_idx,
                                            input logic [3:0] hi_idx);
        return (idx == lo_idx) || (idx == hi_idx);
    endfunction

endpackage

// File: rtl/dsp_wb_regfile_slave_if.sv
// rtl/dsp_wb_regfile_slave_if.sv - Wishbone classic slave bus bundle
interface dsp_wb_regfile_slave_if;
    logic [15:0] ADR_I;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (
        output ADR_I, CYC_I, STB_I, WE_I, DAT_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  ADR_I, CYC_I, STB_I, WE_I, DAT_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/divisor_update_detect.sv
// rtl/divisor_update_detect.sv - one-cycle divisor_update pulse after DSP divisor writes or Wishbone commits
module divisor_update_detect
    import dsp_wb_regfile_slave_pkg::*;
#(
    parameter logic [3:0] DIV_LO_IDX = DIV_LO_IDX_DEFAULT,
    parameter logic [3:0] DIV_HI_IDX = DIV_HI_IDX_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       dsp_wr,
    input  logic [3:0] dsp_idx,
    input  logic       wb_pulse,
    output logic       divisor_update
);

    upd_state_e state_q;
    upd_state_e state_d;
    logic       fsm_pulse;
    logic       upd_q;
    logic       dsp_div_wr;

    assign dsp_div_wr = dsp_wr & is_divisor_idx(dsp_idx, DIV_LO_IDX, DIV_HI_IDX);

    // State register plus last-cycle output, used to keep adjacent sources from stretching the pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upd_q   <= divisor_update;
        end
    end

    // Track a burst of DSP divisor writes; pulse in the cycle the burst ends
    always_comb begin
        state_d   = state_q;
        fsm_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (dsp_div_wr) begin
                    state_d = WAIT_WRITE_DONE;
                end
            end
            WAIT_WRITE_DONE: begin
                if (!dsp_div_wr) begin
                    state_d   = IDLE;
                    fsm_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign divisor_update = (fsm_pulse | wb_pulse) & ~upd_q;

endmodule

// File: rtl/dsp_wb_regfile_slave.sv
// rtl/dsp_wb_regfile_slave.sv - 16x16 register file shared by a DSP bus and a Wishbone slave port
module dsp_wb_regfile_slave
    import dsp_wb_regfile_slave_pkg::*;
#(
    parameter logic [15:0] BASE_ADR   = BASE_ADR_DEFAULT,
    parameter logic [3:0]  DIV_LO_IDX = DIV_LO_IDX_DEFAULT,
    parameter logic [3:0]  DIV_HI_IDX = DIV_HI_IDX_DEFAULT
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    dsp_wb_regfile_slave_if.slave wb,
    input  logic [15:0]           dsp_addr,
    input  logic [15:0]           dsp_data_i,
    output logic [15:0]           dsp_data_o,
    output logic                  dsp_data_oe,
    input  logic                  nCS,
    input  logic                  nWR,
    input  logic                  nRD,
    output logic [31:0]           divisor_value,
    output logic                  divisor_update
);

    logic [15:0] regs [REG_COUNT];

    logic        dsp_hit, dsp_wr, dsp_rd;
    logic [3:0]  dsp_idx;
    logic        wb_hit, wb_req, wb_collide, wb_commit, ack_o;
    logic [3:0]  wb_idx;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        wb_pulse_q;
    logic        unused_dat_hi;

    assign dsp_idx = dsp_addr[3:0];
    assign dsp_hit = dsp_addr[15:4] == BASE_ADR[15:4];
    assign dsp_wr  = ~nCS & ~nWR & dsp_hit;
    assign dsp_rd  = ~nCS & ~nRD & nWR;

    assign wb_idx = wb.ADR_I[3:0];
    assign wb_hit = wb.ADR_I[15:4] == BASE_ADR[15:4];
    assign wb_req = wb.CYC_I & wb.STB_I & ~ack_q;
    // A DSP write to the same word holds off the Wishbone write until the DSP lets go
    assign wb_collide = wb_req & wb.WE_I & wb_hit & dsp_wr & (dsp_idx == wb_idx);
    // Acknowledge is withdrawn if the master abandons the cycle before the ack lands
    assign ack_o     = ack_q & wb.CYC_I & wb.STB_I;
    assign wb_commit = ack_o & wb.WE_I & wb_hit;

    assign wb.ACK_O       = ack_o;
    assign wb.DAT_O       = ack_o ? dat_q : 32'h0;
    assign dsp_data_oe    = dsp_rd;
    assign divisor_value  = {regs[DIV_HI_IDX], regs[DIV_LO_IDX]};
    assign unused_dat_hi  = ^wb.DAT_I[31:16];

    // Register file writes: Wishbone commit first so a same-edge DSP write wins
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 16'h0;
            end
        end else begin
            if (wb_commit) begin
                regs[wb_idx] <= wb.DAT_I[15:0];
            end
            if (dsp_wr) begin
                regs[dsp_idx] <= dsp_data_i;
            end
        end
    end

    // Bus responses: one-wait-state ack with read data, registered DSP read data, Wishbone divisor pulse
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            dsp_data_o <= 16'h0;
            wb_pulse_q <= 1'b0;
        end else begin
            ack_q      <= wb_req & ~wb_collide;
            dat_q      <= (wb_req & ~wb_collide & ~wb.WE_I & wb_hit) ? {16'h0, regs[wb_idx]} : 32'h0;
            dsp_data_o <= (dsp_rd & dsp_hit) ? regs[dsp_idx] : 16'h0;
            wb_pulse_q <= wb_commit & is_divisor_idx(wb_idx, DIV_LO_IDX, DIV_HI_IDX);
        end
    end

    divisor_update_detect #(
        .DIV_LO_IDX (DIV_LO_IDX),
        .DIV_HI_IDX (DIV_HI_IDX)
    ) u_update_detect (
        .clk            (CLK_I),
        .resetn         (RST_I),
        .dsp_wr         (dsp_wr),
        .dsp_idx        (dsp_idx),
        .wb_pulse       (wb_pulse_q),
        .divisor_update (divisor_update)
    );

endmodule

// File: tb/tb_dsp_wb_regfile_slave.sv
// tb/tb_dsp_wb_regfile_slave.sv - self-checking bench for dsp_wb_regfile_slave
module tb_dsp_wb_regfile_slave;

    logic        clk;
    logic        rst_n;
    logic [15:0] dsp_addr, dsp_data_i, dsp_data_o;
    logic        dsp_data_oe, nCS, nWR, nRD;
    logic [31:0] divisor_value;
    logic        divisor_update;

    dsp_wb_regfile_slave_if wb();

    dsp_wb_regfile_slave dut (
        .CLK_I          (clk),
        .RST_I          (rst_n),
        .wb             (wb),
        .dsp_addr       (dsp_addr),
        .dsp_data_i     (dsp_data_i),
        .dsp_data_o     (dsp_data_o),
        .dsp_data_oe    (dsp_data_oe),
        .nCS            (nCS),
        .nWR            (nWR),
        .nRD            (nRD),
        .divisor_value  (divisor_value),
        .divisor_update (divisor_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, pending ack, and pulse bookkeeping in plain terms
    logic [15:0] mreg [16];
    bit          m_ack_pending, m_wb_pulse_due, m_in_div_burst, m_pulsed_last;
    logic [31:0] m_rdata;
    logic [15:0] m_dsp_rdata;

    function automatic bit is_div(input logic [3:0] i);
        return (i == 4'hA) || (i == 4'hB);
    endfunction

    function automatic bit dsp_writing_div();
        return !nCS && !nWR && dsp_addr[15:4] == 12'h400 && is_div(dsp_addr[3:0]);
    endfunction

    function automatic bit exp_update();
        return ((m_in_div_burst && !dsp_writing_div()) || m_wb_pulse_due) && !m_pulsed_last;
    endfunction

    always @(posedge clk) begin : model
        bit dw, dh, wh, req, blocked, commit, upd;
        logic [3:0] di, wi;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
            m_ack_pending = 0; m_wb_pulse_due = 0; m_in_div_burst = 0; m_pulsed_last = 0;
            m_rdata = 0; m_dsp_rdata = 0;
        end else begin
            di = dsp_addr[3:0];
            wi = wb.ADR_I[3:0];
            dh = dsp_addr[15:4] == 12'h400;
            wh = wb.ADR_I[15:4] == 12'h400;
            dw = !nCS && !nWR && dh;
            upd = exp_update();
            commit = m_ack_pending && wb.CYC_I && wb.STB_I && wb.WE_I && wh;
            req = wb.CYC_I && wb.STB_I && !m_ack_pending;
            blocked = req && wb.WE_I && wh && dw && (di == wi);
            m_rdata = (req && !blocked && !wb.WE_I && wh) ? {16'h0, mreg[wi]} : 32'h0;
            m_dsp_rdata = (!nCS && !nRD && nWR && dh) ? mreg[di] : 16'h0;
            m_ack_pending = req && !blocked;
            m_wb_pulse_due = commit && is_div(wi);
            m_in_div_burst = dw && is_div(di);
            m_pulsed_last = upd;
            if (commit) mreg[wi] = wb.DAT_I[15:0];
            if (dw) mreg[di] = dsp_data_i;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : compare
        bit ack_exp;
        ack_exp = m_ack_pending && wb.CYC_I && wb.STB_I;
        check("ACK_O", {31'h0, wb.ACK_O}, {31'h0, ack_exp});
        check("DAT_O", wb.DAT_O, ack_exp ? m_rdata : 32'h0);
        check("dsp_data_o", {16'h0, dsp_data_o}, {16'h0, m_dsp_rdata});
        check("dsp_data_oe", {31'h0, dsp_data_oe}, {31'h0, (!nCS && !nRD && nWR)});
        check("divisor_value", divisor_value, {mreg[4'hB], mreg[4'hA]});
        check("divisor_update", {31'h0, divisor_update}, {31'h0, exp_update()});
        if (divisor_update) pulse_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dsp_idle();
        nCS = 1; nWR = 1; nRD = 1;
    endtask

    task automatic dsp_write(input logic [15:0] a, input logic [15:0] d);
        nCS = 0; nWR = 0; nRD = 1; dsp_addr = a; dsp_data_i = d;
        tick();
    endtask

    task automatic wb_xfer(input logic [15:0] adr, input bit we, input logic [31:0] d,
                           output int lat, output logic [31:0] rd);
        bit got;
        wb.ADR_I = adr; wb.WE_I = we; wb.DAT_I = d; wb.CYC_I = 1; wb.STB_I = 1;
        lat = 0; rd = 32'h0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wb.ACK_O) begin
                rd = wb.DAT_O;
                got = 1;
            end else begin
                lat++;
                tick();
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_ack_timeout: no ACK_O for address %h within 20 cycles", adr);
        end
        tick();
        wb.CYC_I = 0; wb.STB_I = 0; wb.WE_I = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        int p0;
        logic [31:0] rd;

        rst_n = 0;
        dsp_idle();
        dsp_addr = 16'h0; dsp_data_i = 16'h0;
        wb.ADR_I = 16'h0; wb.CYC_I = 0; wb.STB_I = 0; wb.WE_I = 0; wb.DAT_I = 32'h0;

        // Reset state
        @(negedge clk);
        check("reset_ack", {31'h0, wb.ACK_O}, 32'h0);
        check("reset_divisor_value", divisor_value, 32'h0);
        check("reset_dat_o", wb.DAT_O, 32'h0);
        check("reset_update", {31'h0, divisor_update}, 32'h0);
        tick();
        tick();
        rst_n = 1;
        tick();

        // DSP divisor burst LO, HI, then another address: one pulse on the third cycle
        p0 = pulse_cnt;
        dsp_write(16'h400A, 16'h1234);
        dsp_write(16'h400B, 16'hABCD);
        dsp_addr = 16'h400C; dsp_data_i = 16'h00CC;
        @(negedge clk);
        check("burst_end_pulse", {31'h0, divisor_update}, 32'h1);
        tick();
        dsp_idle();
        repeat (3) tick();
        check("divisor_value_burst", divisor_value, 32'hABCD1234);
        check("burst_pulse_count", pulse_cnt - p0, 1);

        // Wishbone read of the high divisor word
        wb_xfer(16'h400B, 0, 32'h0, lat, rd);
        check("wb_read_latency", lat, 1);
        check("wb_read_data", rd, 32'h0000ABCD);

        // Wishbone write to divisor low word: upper half ignored, pulse the cycle after ACK
        p0 = pulse_cnt;
        wb_xfer(16'h400A, 1, 32'hFFFF0005, lat, rd);
        check("wb_write_latency", lat, 1);
        @(negedge clk);
        check("wb_pulse_after_ack", {31'h0, divisor_update}, 32'h1);
        repeat (3) tick();
        check("divisor_value_wb", divisor_value, 32'hABCD0005);
        check("wb_pulse_count", pulse_cnt - p0, 1);

        // Collision: DSP holds a write to the same word for 3 cycles, Wishbone waits and then wins
        fork
            wb_xfer(16'h4003, 1, 32'h0000_1111, lat, rd);
            begin
                nCS = 0; nWR = 0; dsp_addr = 16'h4003; dsp_data_i = 16'h2222;
                repeat (3) tick();
                dsp_idle();
            end
        join
        check("collision_latency", lat, 4);
        wb_xfer(16'h4003, 0, 32'h0, lat, rd);
        check("collision_final", rd, 32'h0000_1111);

        // Wishbone miss: acked, reads zero, write discarded
        wb_xfer(16'h5000, 0, 32'h0, lat, rd);
        check("miss_read_latency", lat, 1);
        check("miss_read_data", rd, 32'h0);
        wb_xfer(16'h5000, 1, 32'h0000BEEF, lat, rd);
        wb_xfer(16'h4000, 0, 32'h0, lat, rd);
        check("miss_write_discarded", rd, 32'h0);

        // Abort: strobe drops before the ack lands
        p0 = pulse_cnt;
        wb.ADR_I = 16'h400A; wb.WE_I = 1; wb.DAT_I = 32'h7777; wb.CYC_I = 1; wb.STB_I = 1;
        @(negedge clk);
        check("abort_no_ack_req", {31'h0, wb.ACK_O}, 32'h0);
        tick();
        wb.STB_I = 0;
        @(negedge clk);
        check("abort_no_ack", {31'h0, wb.ACK_O}, 32'h0);
        tick();
        wb.CYC_I = 0; wb.WE_I = 0;
        repeat (3) tick();
        check("abort_no_write", divisor_value, 32'hABCD0005);
        check("abort_no_pulse", pulse_cnt - p0, 0);

        // DSP reads: hit then miss
        nCS = 0; nRD = 0; nWR = 1; dsp_addr = 16'h4003;
        @(negedge clk);
        check("dsp_oe_on", {31'h0, dsp_data_oe}, 32'h1);
        tick();
        @(negedge clk);
        check("dsp_read_hit", {16'h0, dsp_data_o}, 32'h1111);
        dsp_addr = 16'h5003;
        tick();
        tick();
        check("dsp_read_miss", {16'h0, dsp_data_o}, 32'h0);
        dsp_idle();
        tick();
        check("dsp_oe_off", {31'h0, dsp_data_oe}, 32'h0);

        // Coincident FSM and Wishbone pulse sources collapse to one pulse
        p0 = pulse_cnt;
        fork
            wb_xfer(16'h400B, 1, 32'h0000_3C3C, lat, rd);
            begin
                tick();
                nCS = 0; nWR = 0; dsp_addr = 16'h400A; dsp_data_i = 16'h0042;
                tick();
                dsp_idle();
            end
        join
        repeat (4) tick();
        check("coincident_pulse_count", pulse_cnt - p0, 1);
        check("coincident_value", divisor_value, 32'h3C3C0042);

        // Reset while the update FSM waits for the burst to end
        nCS = 0; nWR = 0; dsp_addr = 16'h400A; dsp_data_i = 16'h5555;
        tick();
        rst_n = 0;
        tick();
        dsp_idle();
        @(negedge clk);
        check("rst_mid_value", divisor_value, 32'h0);
        check("rst_mid_update", {31'h0, divisor_update}, 32'h0);
        check("rst_mid_dsp_o", {16'h0, dsp_data_o}, 32'h0);
        check("rst_mid_ack", {31'h0, wb.ACK_O}, 32'h0);
        p0 = pulse_cnt;
        tick();
        rst_n = 1;
        repeat (5) tick();
        check("rst_mid_no_pulse", pulse_cnt - p0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_wb_regfile_slave.md
DSP_WB_REGFILE_SLAVE -- requirements
Module: dsp_wb_regfile_slave

Interface
REQ-001 Parameters SHALL be: BASE_ADR, default 16'h4000, upper address nibbles selecting this block; DIV_LO_IDX, default 4'hA, divisor low-word register; DIV_HI_IDX, default 4'hB, divisor high-word register.
REQ-002 CLK_I  in  1  single system clock, all logic on rising edge.
REQ-003 RST_I  in  1  reset, synchronous, active-low.
REQ-004 ADR_I  in  16  Wishbone address; CYC_I, STB_I, WE_I  in  1 each  Wishbone cycle, strobe, write enable.
REQ-005 DAT_I  in  32  Wishbone write data; DAT_O  out  32  Wishbone read data; ACK_O  out  1  Wishbone acknowledge.
REQ-006 dsp_addr  in  16  DSP address; dsp_data_i  in  16  DSP write data; dsp_data_o  out  16  DSP read data; dsp_data_oe  out  1  DSP data-bus drive enable.
REQ-007 nCS, nWR, nRD  in  1 each  DSP chip select, write strobe, read strobe, active-low, synchronous to CLK_I.
REQ-008 divisor_value  out  32  {reg[DIV_HI_IDX], reg[DIV_LO_IDX]}; divisor_update  out  1  one-cycle pulse on divisor change.

Function
REQ-009 Storage SHALL be 16 x 16-bit registers, index = address[3:0]; hit = address[15:4] == BASE_ADR[15:4].
REQ-010 DSP write: every cycle with nCS=0, nWR=0 and hit, reg[dsp_addr[3:0]] <= dsp_data_i.
REQ-011 DSP read: dsp_data_o registered, = reg[dsp_addr[3:0]] one cycle after nCS=0, nRD=0, nWR=1; 0 on miss; dsp_data_oe = ~nCS & ~nRD & nWR, combinational.
REQ-012 Wishbone request = CYC_I & STB_I & ~ACK_O; ACK_O SHALL assert one cycle after request, for exactly one cycle (one wait state).
REQ-013 ACK_O SHALL be withheld if STB_I or CYC_I drops before ACK (abort, no write, no update).
REQ-014 Wishbone write: DAT_I[15:0] written on ACK cycle; DAT_I[31:16] ignored.
REQ-015 Wishbone read: DAT_O = {16'h0, reg[index]} valid on ACK cycle; DAT_O = 0 otherwise.
REQ-016 Wishbone miss: ACK still given, read returns 0, write discarded.
REQ-017 Collision: DSP write and Wishbone write pending to same index same cycle -> DSP wins, Wishbone ACK deferred until DSP write to that index ends, then Wishbone write commits.
REQ-018 Update FSM states IDLE, WAIT_WRITE_DONE; IDLE -> WAIT_WRITE_DONE on DSP write to DIV_LO_IDX or DIV_HI_IDX.
REQ-019 WAIT_WRITE_DONE holds while DSP write to either divisor index continues (consecutive LO then HI writes stay in state); exits to IDLE when none, pulsing divisor_update in the exit cycle.
REQ-020 Wishbone write committing to a divisor index SHALL pulse divisor_update the cycle after ACK_O.
REQ-021 Coincident FSM and Wishbone pulse sources SHALL yield a single one-cycle pulse, never a stretched pulse.
REQ-022 divisor_value SHALL reflect registers combinationally, updated the cycle after the write edge.

Reset
REQ-023 While RST_I=0 at a rising edge: all registers 0, ACK_O=0, dsp_data_o=0, DAT_O=0, divisor_update=0, FSM=IDLE.
REQ-024 Reset mid-transaction SHALL abort it: no ACK, no pulse after release; a held DSP write resumes normal behaviour from IDLE.

Structure
REQ-025 FSM state encodings, register count and DIV_LO/DIV_HI default indices SHALL live in a shared package used by the clock divisor master.
REQ-026 Update FSM SHALL be one sub-module, divisor_update_detect; register file and Wishbone/DSP ports stay in the top.

Verification
REQ-027 DSP write 16'h1234 @0x400A, then 16'hABCD @0x400B, then address 0x400C -> divisor_value=32'hABCD1234, exactly one divisor_update pulse on the 0x400C cycle.
REQ-028 Wishbone read ADR_I=0x400B after REQ-027 -> ACK_O one cycle after STB, DAT_O=32'h0000ABCD.
REQ-029 Wishbone write 32'hFFFF0005 @0x400A -> reg=16'h0005, divisor_update pulses cycle after ACK, no pulse repeat.
REQ-030 Wishbone write 16'h1111 and DSP write 16'h2222 same cycle to 0x4003, DSP held 3 cycles -> ACK deferred 3 cycles, final reg = 16'h1111.
REQ-031 Wishbone access ADR_I=0x5000 -> ACK_O given, DAT_O=0, no register changes; STB_I dropped before ACK -> no ACK.
REQ-032 RST_I=0 during WAIT_WRITE_DONE -> all outputs 0, no divisor_update after release.
